// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM channel.
//   pwm_state_e       - channel FSM state encoding (IDLE / RUN / STOP)
//   PWM_DEFAULT_WIDTH - default width of counter, top and duty
package pwm_pkg;

  localparam int unsigned PWM_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/tick_sync_edge.sv
// tick_sync_edge: SYNC_STAGES-deep synchroniser followed by a rising-edge
// detector for a tick level produced on a foreign clock.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous, active-high reset
//   tick_in in  asynchronous tick level
//   tick_p  out one-clk pulse per rising edge of tick_in
// Reset clears every flop, so a level already high at reset release counts
// as one edge.
module tick_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic tick_p
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    tick_p = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

endmodule

// File: rtl/pwm_channel.sv
// pwm_channel: tick-driven PWM generator with a shadowed top/duty config.
// Ports:
//   clk          in  system clock
//   rst          in  asynchronous, active-high reset
//   tick_in      in  timer tick level; each rising edge advances the period
//   en           in  run request
//   cfg_valid    in  new top/duty offered
//   cfg_ready    out shadow slot free
//   cfg_top      in  period length minus 1, in ticks
//   cfg_duty     in  high ticks per period
//   pwm_out      out registered PWM output
//   period_start out one-clk pulse when a period begins
//   running      out high while in RUN or STOP
// New configs sit in a shadow until a period boundary (or straight away when
// idle), so the live waveform never sees a half-updated top/duty pair.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = PWM_DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_top,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_start,
  output logic             running
);

  pwm_state_e       state_q, state_n;
  logic [WIDTH-1:0] cnt_q, cnt_n;
  logic [WIDTH-1:0] top_q, top_n;
  logic [WIDTH-1:0] duty_q, duty_n;
  logic [WIDTH-1:0] top_sh_q, duty_sh_q;
  logic             loaded_q, loaded_n;
  logic             pending_q, pending_n;
  logic             ps_q, ps_n;
  logic             pwm_q, pwm_n;
  logic             tick_p;
  logic             accept;

  tick_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_in(tick_in),
    .tick_p (tick_p)
  );

  always_comb begin
    accept = cfg_valid & ~pending_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      top_q     <= '0;
      duty_q    <= '0;
      top_sh_q  <= '0;
      duty_sh_q <= '0;
      loaded_q  <= 1'b0;
      pending_q <= 1'b0;
      ps_q      <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      top_q     <= top_n;
      duty_q    <= duty_n;
      loaded_q  <= loaded_n;
      pending_q <= pending_n;
      ps_q      <= ps_n;
      pwm_q     <= pwm_n;
      if (accept) begin
        top_sh_q  <= cfg_top;
        duty_sh_q <= cfg_duty;
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    top_n     = top_q;
    duty_n    = duty_q;
    loaded_n  = loaded_q;
    pending_n = pending_q | accept;
    ps_n      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (pending_q) begin
          top_n     = top_sh_q;
          duty_n    = duty_sh_q;
          loaded_n  = 1'b1;
          pending_n = 1'b0;
        end
        if (en && loaded_q) begin
          state_n = RUN;
          ps_n    = 1'b1;
        end
      end
      RUN, STOP: begin
        state_n = en ? RUN : STOP;
        if (tick_p) begin
          if (cnt_q == top_q) begin
            cnt_n = '0;
            // A config accepted on the wrap cycle itself bypasses the shadow
            // so it lands on this boundary rather than one period later.
            if (pending_q) begin
              top_n     = top_sh_q;
              duty_n    = duty_sh_q;
              pending_n = 1'b0;
            end else if (accept) begin
              top_n     = cfg_top;
              duty_n    = cfg_duty;
              pending_n = 1'b0;
            end
            if (en) begin
              state_n = RUN;
              ps_n    = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    pwm_n        = (state_n != IDLE) && (cnt_n < duty_n);
    pwm_out      = pwm_q;
    period_start = ps_q;
    running      = (state_q != IDLE);
    cfg_ready    = ~pending_q;
  end

endmodule

// File: tb/tb_pwm_channel.sv
// tb_pwm_channel: directed self-checking bench for pwm_channel
// (WIDTH=16, SYNC_STAGES=2, 10 ns clock).
module tb_pwm_channel;

  logic        clk;
  logic        rst;
  logic        tick_in;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_top;
  logic [15:0] cfg_duty;
  logic        pwm_out;
  logic        period_start;
  logic        running;

  int unsigned n_checks;
  int unsigned n_fail;

  pwm_channel #(
    .WIDTH      (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_in     (tick_in),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_top     (cfg_top),
    .cfg_duty    (cfg_duty),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // One tick: rising edge 1 ns after a posedge, update lands SYNC_STAGES+1
  // edges later. pre_pw is sampled one edge before the update, post values
  // right after it. Optionally offers a config on the update (wrap) cycle.
  task automatic do_tick(input logic with_cfg, input logic [15:0] t, input logic [15:0] d,
                         output logic pre_pw, output logic pw, output logic ps, output logic rdy);
    @(posedge clk); #1 tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    if (with_cfg) begin
      #1 cfg_valid = 1'b1; cfg_top = t; cfg_duty = d;
    end
    @(negedge clk); pre_pw = pwm_out;
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(negedge clk); pw = pwm_out; ps = period_start; rdy = cfg_ready;
    @(posedge clk); #1 tick_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; cfg_valid = 1'b0; tick_in = 1'b0; cfg_top = '0; cfg_duty = '0;
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_idle(input logic [15:0] t, input logic [15:0] d);
    @(posedge clk); #1 cfg_valid = 1'b1; cfg_top = t; cfg_duty = d;
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; tick_in = 1'b0; cfg_top = '0; cfg_duty = '0;
    #12;
    n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_ps: got %b want 0", period_start); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0", running); end
  endtask

  task automatic test_basic();
    logic exp_pw [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_ps [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic pre, pw, ps, rdy, prev;
    @(posedge clk); #1 cfg_valid = 1'b1; cfg_top = 16'd4; cfg_duty = 16'd2;
    @(posedge clk); #1 cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_fall: got %b want 0", cfg_ready); end
    @(posedge clk); #1;
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_idle_apply: got %b want 1", cfg_ready); end
    en = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL basic_entry_running: got %b want 1", running); end
    n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL basic_entry_ps: got %b want 1", period_start); end
    n_checks++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL basic_entry_pwm: got %b want 1", pwm_out); end
    @(posedge clk); #1;
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL basic_ps_width: got %b want 0", period_start); end
    prev = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
      n_checks++; if (pre !== prev) begin n_fail++; $display("FAIL basic_latency tick %0d: early pwm %b want %b", i + 1, pre, prev); end
      n_checks++; if (pw !== exp_pw[i]) begin n_fail++; $display("FAIL basic_pwm tick %0d: got %b want %b", i + 1, pw, exp_pw[i]); end
      n_checks++; if (ps !== exp_ps[i]) begin n_fail++; $display("FAIL basic_ps tick %0d: got %b want %b", i + 1, ps, exp_ps[i]); end
      prev = exp_pw[i];
    end
  endtask

  task automatic test_reconfig();
    logic exp_pw [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic pre, pw, ps, rdy, prev;
    do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
    n_checks++; if (pw !== 1'b1) begin n_fail++; $display("FAIL reconfig_pre_pwm: got %b want 1", pw); end
    @(posedge clk); #1 cfg_valid = 1'b1; cfg_top = 16'd9; cfg_duty = 16'd7;
    @(posedge clk); #1 cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reconfig_ready_fall: got %b want 0", cfg_ready); end
    prev = 1'b1;
    for (int i = 0; i < 14; i++) begin
      do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
      n_checks++; if (pre !== prev) begin n_fail++; $display("FAIL reconfig_latency tick %0d: early pwm %b want %b", i, pre, prev); end
      n_checks++; if (pw !== exp_pw[i]) begin n_fail++; $display("FAIL reconfig_pwm tick %0d: got %b want %b", i, pw, exp_pw[i]); end
      n_checks++; if (ps !== ((i == 3) || (i == 13))) begin n_fail++; $display("FAIL reconfig_ps tick %0d: got %b want %b", i, ps, ((i == 3) || (i == 13))); end
      n_checks++; if (rdy !== (i >= 3)) begin n_fail++; $display("FAIL reconfig_ready tick %0d: got %b want %b", i, rdy, (i >= 3)); end
      prev = exp_pw[i];
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] tops  [3] = '{16'd4, 16'd4, 16'd0};
    logic [15:0] duties[3] = '{16'd0, 16'd5, 16'd1};
    logic        lvl   [3] = '{1'b0, 1'b1, 1'b1};
    logic pre, pw, ps, rdy, eps;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      load_idle(tops[k], duties[k]);
      en = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (pwm_out !== lvl[k]) begin n_fail++; $display("FAIL bound%0d_entry_pwm: got %b want %b", k, pwm_out, lvl[k]); end
      n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL bound%0d_entry_ps: got %b want 1", k, period_start); end
      for (int j = 0; j < 5; j++) begin
        do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
        eps = (k == 2) || (j == 4);
        n_checks++; if (pre !== lvl[k]) begin n_fail++; $display("FAIL bound%0d_pre tick %0d: got %b want %b", k, j, pre, lvl[k]); end
        n_checks++; if (pw !== lvl[k]) begin n_fail++; $display("FAIL bound%0d_pwm tick %0d: got %b want %b", k, j, pw, lvl[k]); end
        n_checks++; if (ps !== eps) begin n_fail++; $display("FAIL bound%0d_ps tick %0d: got %b want %b", k, j, ps, eps); end
      end
    end
  endtask

  task automatic test_en_drop();
    logic pre, pw, ps, rdy;
    do_reset();
    load_idle(16'd4, 16'd2);
    en = 1'b1;
    @(posedge clk); #1;
    do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
    do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
    n_checks++; if (pw !== 1'b0) begin n_fail++; $display("FAIL drop_cnt2_pwm: got %b want 0", pw); end
    en = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL drop_stop_running: got %b want 1", running); end
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
      n_checks++; if (pw !== 1'b0) begin n_fail++; $display("FAIL drop_pwm tick %0d: got %b want 0", i, pw); end
      n_checks++; if (ps !== 1'b0) begin n_fail++; $display("FAIL drop_ps tick %0d: got %b want 0", i, ps); end
      n_checks++; if (running !== (i < 2)) begin n_fail++; $display("FAIL drop_running tick %0d: got %b want %b", i, running, (i < 2)); end
    end
    en = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL resume_entry_ps: got %b want 1", period_start); end
    do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
    do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
    en = 1'b0;
    do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL resume_stop_running: got %b want 1", running); end
    en = 1'b1;
    do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
    n_checks++; if (pw !== 1'b0 || ps !== 1'b0) begin n_fail++; $display("FAIL resume_cnt4: got pwm %b ps %b want 0 0", pw, ps); end
    do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
    n_checks++; if (pw !== 1'b1 || ps !== 1'b1) begin n_fail++; $display("FAIL resume_wrap: got pwm %b ps %b want 1 1", pw, ps); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running: got %b want 1", running); end
  endtask

  task automatic test_hold_and_wrap_cfg();
    logic pre, pw, ps, rdy;
    int unsigned ps_cnt;
    do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
    ps_cnt = 0;
    @(posedge clk); #1 tick_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (period_start) ps_cnt++;
    end
    @(posedge clk); #1 tick_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (ps_cnt !== 0) begin n_fail++; $display("FAIL hold_ps_count: got %0d want 0", ps_cnt); end
    n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL hold_pwm: got %b want 0", pwm_out); end
    for (int i = 0; i < 2; i++) begin
      do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
      n_checks++; if (pw !== 1'b0 || ps !== 1'b0) begin n_fail++; $display("FAIL hold_after tick %0d: got pwm %b ps %b want 0 0", i, pw, ps); end
    end
    do_tick(1'b1, 16'd2, 16'd1, pre, pw, ps, rdy);
    n_checks++; if (pw !== 1'b1 || ps !== 1'b1) begin n_fail++; $display("FAIL wrapcfg_wrap: got pwm %b ps %b want 1 1", pw, ps); end
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL wrapcfg_ready: got %b want 1", rdy); end
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
      n_checks++; if (pw !== (i == 2)) begin n_fail++; $display("FAIL wrapcfg_pwm tick %0d: got %b want %b", i, pw, (i == 2)); end
      n_checks++; if (ps !== (i == 2)) begin n_fail++; $display("FAIL wrapcfg_ps tick %0d: got %b want %b", i, ps, (i == 2)); end
    end
  endtask

  task automatic test_async_reset();
    logic pre, pw, ps, rdy;
    @(posedge clk); #1 cfg_valid = 1'b1; cfg_top = 16'd4; cfg_duty = 16'd3;
    @(posedge clk); #1 cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL areset_pending: got %b want 0", cfg_ready); end
    n_checks++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL areset_pre_pwm: got %b want 1", pwm_out); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL areset_pwm: got %b want 0", pwm_out); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL areset_running: got %b want 0", running); end
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL areset_ps: got %b want 0", period_start); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b want 1", cfg_ready); end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_tick(1'b0, '0, '0, pre, pw, ps, rdy);
      n_checks++; if (pw !== 1'b0 || ps !== 1'b0) begin n_fail++; $display("FAIL areset_norestart tick %0d: got pwm %b ps %b want 0 0", i, pw, ps); end
    end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL areset_still_idle: got %b want 0", running); end
    en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_reconfig();
    test_boundaries();
    test_en_drop();
    test_hold_and_wrap_cfg();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
